// File: rtl/spi_cmd_pkg.sv
// Shared types and command codes for the SPI command sequencer.
// Optional status-read path is enabled by defining SPI_CMD_CTRL_STATUS_RD_EN.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    CONF    = 3'd2,
    DATA    = 3'd3,
    STAT    = 3'd4,
    DISCARD = 3'd5
  } spi_cmd_state_t;

  localparam logic [7:0] CMD_CONF_WR = 8'h2A;
  localparam logic [7:0] CMD_DATA_WR = 8'h2B;
  localparam logic [7:0] CMD_STAT_RD = 8'h2C;

  // Low byte of a counter, used to report frame lengths over an 8-bit bus.
  function automatic logic [7:0] lsb8(input logic [15:0] value);
    return value[7:0];
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_edge_sync.sv
// N-stage synchronizer for an asynchronous level, with registered
// single-cycle rise/fall pulses on the synchronized value.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;
  logic              rise_r;
  logic              fall_r;

  // The chain keeps sampling through reset so a level already present when
  // reset drops is not mistaken for a fresh edge afterwards.
  always_ff @(posedge clk_i) begin
    sync_r <= {sync_r[STAGES-2:0], d_i};
    prev_r <= sync_r[STAGES-1];
    if (rst_i) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= sync_r[STAGES-1] & ~prev_r;
      fall_r <= ~sync_r[STAGES-1] & prev_r;
    end
  end

  assign rise_o = rise_r;
  assign fall_o = fall_r;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command/frame sequencer behind spi_slave: decodes the first byte of each
// chip-select frame. Status read-back is enabled by SPI_CMD_CTRL_STATUS_RD_EN.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter int CS_SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_byte_vld_i,
  input  logic [7:0]        spi_byte_data_i,
  output logic [7:0]        spi_byte_data_o,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [7:0]        ram_wr_data_o,
  output logic              cfg_wr_en_o,
  output logic [7:0]        cfg_data_o,
  output logic              frame_done_o,
  output logic [ADDR_W:0]   frame_len_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic cs_rise_s;
  logic cs_fall_s;

  edge_sync #(
    .STAGES(CS_SYNC_STAGES)
  ) u_cs_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (spi_cs_n_i),
    .rise_o (cs_rise_s),
    .fall_o (cs_fall_s)
  );

  spi_cmd_state_t    state_r;
  logic [ADDR_W:0]   addr_cnt_r;
  logic [ADDR_W:0]   byte_cnt_r;
  logic [ADDR_W:0]   frame_len_r;
  logic              ram_wr_en_r;
  logic [ADDR_W-1:0] ram_wr_addr_r;
  logic [7:0]        ram_wr_data_r;
  logic              cfg_wr_en_r;
  logic [7:0]        cfg_data_r;
  logic              frame_done_r;
  logic              overflow_r;
  logic              data_acc_s;
  logic              data_drop_s;
  logic [ADDR_W:0]   byte_cnt_inc_s;

`ifdef SPI_CMD_CTRL_STATUS_RD_EN
  logic [7:0]        miso_r;
`endif

  // A data byte is accepted while the address counter has not reached the
  // RAM depth; its MSB is set exactly when the counter equals the depth.
  always_comb begin
    data_acc_s     = 1'b0;
    data_drop_s    = 1'b0;
    byte_cnt_inc_s = CNT_ZERO;
    if ((state_r == DATA) && spi_byte_vld_i) begin
      data_acc_s  = ~addr_cnt_r[ADDR_W];
      data_drop_s = addr_cnt_r[ADDR_W];
    end else begin
      data_acc_s  = 1'b0;
      data_drop_s = 1'b0;
    end
    if (data_acc_s) begin
      byte_cnt_inc_s = CNT_ONE;
    end else begin
      byte_cnt_inc_s = CNT_ZERO;
    end
  end

  // Frame sequencer; all outputs are registered here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      addr_cnt_r    <= CNT_ZERO;
      byte_cnt_r    <= CNT_ZERO;
      frame_len_r   <= CNT_ZERO;
      ram_wr_en_r   <= 1'b0;
      ram_wr_addr_r <= {ADDR_W{1'b0}};
      ram_wr_data_r <= 8'h00;
      cfg_wr_en_r   <= 1'b0;
      cfg_data_r    <= 8'h00;
      frame_done_r  <= 1'b0;
      overflow_r    <= 1'b0;
`ifdef SPI_CMD_CTRL_STATUS_RD_EN
      miso_r        <= 8'h00;
`endif
    end else begin
      ram_wr_en_r  <= 1'b0;
      cfg_wr_en_r  <= 1'b0;
      frame_done_r <= 1'b0;

      case (state_r)
        IDLE: begin
          if (cs_fall_s) begin
            state_r    <= CMD;
            overflow_r <= 1'b0;
            byte_cnt_r <= CNT_ZERO;
          end
        end
        CMD: begin
          if (spi_byte_vld_i) begin
            case (spi_byte_data_i)
              CMD_CONF_WR: state_r <= CONF;
              CMD_DATA_WR: begin
                state_r    <= DATA;
                addr_cnt_r <= CNT_ZERO;
              end
`ifdef SPI_CMD_CTRL_STATUS_RD_EN
              CMD_STAT_RD: begin
                state_r <= STAT;
                miso_r  <= {overflow_r, cfg_data_r[6:0]};
              end
`endif
              default: state_r <= DISCARD;
            endcase
          end
        end
        CONF: begin
          if (spi_byte_vld_i) begin
            cfg_data_r  <= spi_byte_data_i;
            cfg_wr_en_r <= 1'b1;
            state_r     <= DISCARD;
          end
        end
        DATA: begin
          if (data_acc_s) begin
            ram_wr_en_r   <= 1'b1;
            ram_wr_addr_r <= addr_cnt_r[ADDR_W-1:0];
            ram_wr_data_r <= spi_byte_data_i;
            addr_cnt_r    <= addr_cnt_r + CNT_ONE;
            byte_cnt_r    <= byte_cnt_r + CNT_ONE;
          end else if (data_drop_s) begin
            overflow_r <= 1'b1;
          end
        end
        STAT: begin
`ifdef SPI_CMD_CTRL_STATUS_RD_EN
          if (spi_byte_vld_i) begin
            miso_r <= lsb8(16'(frame_len_r));
          end
`endif
        end
        DISCARD: begin
          state_r <= DISCARD;
        end
        default: state_r <= IDLE;
      endcase

      // Frame end overrides the state update above; a byte arriving in the
      // same cycle has already been processed and is included in the length.
      if (cs_rise_s && (state_r != IDLE)) begin
        state_r <= IDLE;
`ifdef SPI_CMD_CTRL_STATUS_RD_EN
        miso_r  <= 8'h00;
`endif
        if (state_r == DATA) begin
          frame_done_r <= 1'b1;
          frame_len_r  <= byte_cnt_r + byte_cnt_inc_s;
        end
      end
    end
  end

`ifdef SPI_CMD_CTRL_STATUS_RD_EN
  assign spi_byte_data_o = miso_r;
`else
  assign spi_byte_data_o = 8'h00;
`endif

  assign ram_wr_en_o   = ram_wr_en_r;
  assign ram_wr_addr_o = ram_wr_addr_r;
  assign ram_wr_data_o = ram_wr_data_r;
  assign cfg_wr_en_o   = cfg_wr_en_r;
  assign cfg_data_o    = cfg_data_r;
  assign frame_done_o  = frame_done_r;
  assign frame_len_o   = frame_len_r;
  assign overflow_o    = overflow_r;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Scoreboard bench for spi_cmd_ctrl with a small RAM (ADDR_W=2) so the
// overflow boundary is reachable; honours SPI_CMD_CTRL_STATUS_RD_EN.
module tb_spi_cmd_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

`ifdef SPI_CMD_CTRL_STATUS_RD_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs_n = 1'b1;
  logic          vld = 1'b0;
  logic [7:0]    din = 8'h00;
  logic [7:0]    miso;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [7:0]    ram_wr_data;
  logic          cfg_wr_en;
  logic [7:0]    cfg_data;
  logic          frame_done;
  logic [AW:0]   frame_len;
  logic          overflow;

  always #5 clk = ~clk;

  spi_cmd_ctrl #(.ADDR_W(AW), .CS_SYNC_STAGES(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .spi_cs_n_i      (cs_n),
    .spi_byte_vld_i  (vld),
    .spi_byte_data_i (din),
    .spi_byte_data_o (miso),
    .ram_wr_en_o     (ram_wr_en),
    .ram_wr_addr_o   (ram_wr_addr),
    .ram_wr_data_o   (ram_wr_data),
    .cfg_wr_en_o     (cfg_wr_en),
    .cfg_data_o      (cfg_data),
    .frame_done_o    (frame_done),
    .frame_len_o     (frame_len),
    .overflow_o      (overflow)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t        ram_q[$];
  int         cfg_q[$];
  int         done_q[$];
  logic [7:0] payload[$];

  int errors = 0;
  int checks = 0;

  // Reference state: what the spec says the held outputs must show.
  int m_cfg = 0;
  int m_len = 0;
  int m_ovf = 0;

  logic vld_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT raises a strobe.
  always @(negedge clk) begin
    if (ram_wr_en) begin
      check("ram_wr_latency", int'(vld_prev), 1);
      if (ram_q.size() == 0) begin
        check("ram_wr_unexpected", 1, 0);
      end else begin
        wr_t e;
        e = ram_q.pop_front();
        check("ram_wr_addr", int'(ram_wr_addr), e.addr);
        check("ram_wr_data", int'(ram_wr_data), e.data);
      end
    end
    if (cfg_wr_en) begin
      check("cfg_wr_latency", int'(vld_prev), 1);
      if (cfg_q.size() == 0) begin
        check("cfg_wr_unexpected", 1, 0);
      end else begin
        check("cfg_wr_data", int'(cfg_data), cfg_q.pop_front());
      end
    end
    if (frame_done) begin
      if (done_q.size() == 0) begin
        check("frame_done_unexpected", 1, 0);
      end else begin
        check("frame_len_at_done", int'(frame_len), done_q.pop_front());
      end
    end
    vld_prev = vld;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    din = b;
    vld = 1'b1;
    tick(1);
    vld = 1'b0;
    din = 8'h00;
    tick($urandom_range(0, 2));
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(8);
    m_ovf = 0;
    check("overflow_cleared_at_start", int'(overflow), 0);
  endtask

  task automatic cs_high();
    cs_n = 1'b1;
    tick(10);
    check("cfg_data_held", int'(cfg_data), m_cfg);
    check("frame_len_held", int'(frame_len), m_len);
    check("overflow_after_frame", int'(overflow), m_ovf);
    check("miso_idle", int'(miso), 0);
  endtask

  // Send one frame: command byte followed by the contents of payload.
  task automatic run_frame(input logic [7:0] cmd);
    int  n;
    bit  stat;
    int  exp_miso;
    n    = payload.size();
    stat = STAT_EN && (cmd == 8'h2C);
    cs_low();
    check("miso_before_cmd", int'(miso), 0);
    send_byte(cmd);
    exp_miso = stat ? ((m_ovf << 7) | (m_cfg & 8'h7F)) : 0;
    check("miso_after_cmd", int'(miso), exp_miso);
    for (int i = 0; i < n; i++) begin
      if (cmd == 8'h2A && i == 0) begin
        cfg_q.push_back(int'(payload[i]));
        m_cfg = int'(payload[i]);
      end
      if (cmd == 8'h2B) begin
        if (i < DEPTH) begin
          wr_t w;
          w.addr = i;
          w.data = int'(payload[i]);
          ram_q.push_back(w);
        end else begin
          m_ovf = 1;
        end
      end
      send_byte(payload[i]);
      exp_miso = stat ? (m_len & 8'hFF) : 0;
      check("miso_after_byte", int'(miso), exp_miso);
    end
    if (cmd == 8'h2B) begin
      m_len = (n < DEPTH) ? n : DEPTH;
      done_q.push_back(m_len);
    end
    cs_high();
  endtask

  initial begin
    tick(6);
    check("rst_ram_wr_en", int'(ram_wr_en), 0);
    check("rst_ram_wr_addr", int'(ram_wr_addr), 0);
    check("rst_ram_wr_data", int'(ram_wr_data), 0);
    check("rst_cfg_wr_en", int'(cfg_wr_en), 0);
    check("rst_cfg_data", int'(cfg_data), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_len", int'(frame_len), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_miso", int'(miso), 0);
    rst = 1'b0;
    tick(4);

    payload = '{8'h5C, 8'h11};
    run_frame(8'h2A);
    payload = '{8'h01, 8'h02, 8'h03};
    run_frame(8'h2B);
    payload = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_frame(8'h2B);
    check("overflow_sticky", int'(overflow), 1);
    payload = '{8'hFF, 8'hFF};
    run_frame(8'h7E);
    payload = '{};
    run_frame(8'h2B);

    payload = '{8'h05};
    run_frame(8'h2A);
    payload = '{8'h10, 8'h20, 8'h30};
    run_frame(8'h2B);
    payload = '{8'h99, 8'h98};
    run_frame(8'h2C);

    // Reset in the middle of a data frame.
    cs_low();
    begin
      wr_t w;
      w.addr = 0;
      w.data = 8'hAA;
      ram_q.push_back(w);
    end
    send_byte(8'h2B);
    send_byte(8'hAA);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    m_cfg = 0;
    m_len = 0;
    m_ovf = 0;
    check("midrst_cfg_data", int'(cfg_data), 0);
    check("midrst_frame_len", int'(frame_len), 0);
    check("midrst_overflow", int'(overflow), 0);
    send_byte(8'hBB);
    cs_high();
    payload = '{8'h44, 8'h55};
    run_frame(8'h2B);

    for (int f = 0; f < 30; f++) begin
      int         sel;
      int         n;
      logic [7:0] cmd;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       cmd = 8'h2A;
        1:       cmd = 8'h2B;
        2:       cmd = 8'h2C;
        default: cmd = 8'($urandom_range(0, 255));
      endcase
      n = $urandom_range(0, 6);
      payload.delete();
      for (int k = 0; k < n; k++) begin
        payload.push_back(8'($urandom_range(0, 255)));
      end
      run_frame(cmd);
    end

    tick(5);
    check("ram_q_drained", ram_q.size(), 0);
    check("cfg_q_drained", cfg_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
